// File: rtl/bus_ctrl.sv
// CPU-side bus controller: decodes address regions, drives per-region strobes,
// and stalls the CPU for a fixed wait count or until a slave acknowledge or timeout.
module bus_ctrl #(
  parameter int                          ADDR_W   = 16,
  parameter int                          DATA_W   = 8,
  parameter int                          NUM_SLV  = 4,
  parameter int                          WAIT_W   = 4,
  parameter logic [NUM_SLV*ADDR_W-1:0]   REG_BASE = '0,
  parameter logic [NUM_SLV*ADDR_W-1:0]   REG_MASK = '0,
  parameter logic [NUM_SLV*WAIT_W-1:0]   REG_WAIT = '0,
  parameter logic [NUM_SLV-1:0]          REG_ACK  = '0,
  parameter int                          TMO      = 16,
  parameter logic [DATA_W-1:0]           DEF_DATA = DATA_W'(8'hFF)
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  input  logic                        cpu_rd,
  input  logic                        cpu_we,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        cpu_rdy,
  output logic [NUM_SLV-1:0]          slv_cs,
  output logic [ADDR_W-1:0]           slv_addr,
  output logic                        slv_rd,
  output logic                        slv_we,
  output logic [DATA_W-1:0]           slv_wdata,
  input  logic [NUM_SLV*DATA_W-1:0]   slv_rdata,
  input  logic [NUM_SLV-1:0]          slv_ack,
  output logic                        bus_err,
  input  logic                        err_clr
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int TMO_W = $clog2(TMO + 1);
  localparam int CNT_W = (WAIT_W > TMO_W) ? WAIT_W : TMO_W;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   sel;
  logic               hit;
  logic               ack_mode;
  logic               is_wr;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [NUM_SLV-1:0] dec_cs;
  logic [CNT_W-1:0]   dec_cnt;
  logic [ADDR_W-1:0]  dec_off;
  logic               ack_now;
  logic               timeout;
  logic               last;
  logic               err_set;

  // Scan from the top so the lowest matching region wins on overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((cpu_addr & REG_MASK[i*ADDR_W +: ADDR_W]) == REG_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_idx = IDX_W'(i);
      end
    end
    dec_cs  = dec_hit ? (NUM_SLV'(1) << dec_idx) : '0;
    dec_off = dec_hit ? (cpu_addr & ~REG_MASK[dec_idx*ADDR_W +: ADDR_W]) : '0;
    if (!dec_hit)
      dec_cnt = '0;
    else if (REG_ACK[dec_idx])
      dec_cnt = CNT_W'(TMO - 1);
    else
      dec_cnt = CNT_W'(REG_WAIT[dec_idx*WAIT_W +: WAIT_W]);
  end

  always_comb begin
    ack_now = slv_ack[sel];
    timeout = (state == ACCESS) && hit && ack_mode && !ack_now && (cnt == '0);
    last    = (state == ACCESS) && (!hit || (ack_mode ? (ack_now || cnt == '0) : (cnt == '0)));
    err_set = last && (!hit || timeout);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel       <= '0;
      hit       <= 1'b0;
      ack_mode  <= 1'b0;
      is_wr     <= 1'b0;
      cpu_rdata <= '0;
      cpu_rdy   <= 1'b1;
      slv_cs    <= '0;
      slv_addr  <= '0;
      slv_rd    <= 1'b0;
      slv_we    <= 1'b0;
      slv_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      // A new error outranks a clear issued on the same edge.
      bus_err <= err_set | (bus_err & ~err_clr);
      case (state)
        IDLE: begin
          if (cpu_rd || cpu_we) begin
            state     <= ACCESS;
            cpu_rdy   <= 1'b0;
            is_wr     <= cpu_we;
            hit       <= dec_hit;
            sel       <= dec_idx;
            ack_mode  <= dec_hit & REG_ACK[dec_idx];
            cnt       <= dec_cnt;
            slv_cs    <= dec_cs;
            slv_rd    <= dec_hit & ~cpu_we;
            slv_we    <= dec_hit & cpu_we;
            slv_addr  <= dec_off;
            slv_wdata <= cpu_wdata;
          end
        end
        ACCESS: begin
          if (last) begin
            state   <= DONE;
            cpu_rdy <= 1'b1;
            slv_cs  <= '0;
            slv_rd  <= 1'b0;
            slv_we  <= 1'b0;
            cnt     <= '0;
            if (!is_wr)
              cpu_rdata <= (hit && !timeout) ? slv_rdata[sel*DATA_W +: DATA_W] : DEF_DATA;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: three regions (fixed-wait, multi-wait, ack-mode)
// plus unmapped, timeout, error-clear priority and mid-access reset.
module tb_bus_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_rd;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdy;
  logic [2:0]  slv_cs;
  logic [15:0] slv_addr;
  logic        slv_rd;
  logic        slv_we;
  logic [7:0]  slv_wdata;
  logic [23:0] slv_rdata;
  logic [2:0]  slv_ack;
  logic        bus_err;
  logic        err_clr;

  int checks = 0;
  int failures = 0;

  bus_ctrl #(
    .ADDR_W  (16),
    .DATA_W  (8),
    .NUM_SLV (3),
    .WAIT_W  (4),
    .REG_BASE({16'hF000, 16'hA000, 16'h0000}),
    .REG_MASK({16'hFFFE, 16'hE000, 16'h8000}),
    .REG_WAIT({4'd0, 4'd2, 4'd0}),
    .REG_ACK (3'b100),
    .TMO     (8),
    .DEF_DATA(8'hFF)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rd   (cpu_rd),
    .cpu_we   (cpu_we),
    .cpu_rdata(cpu_rdata),
    .cpu_rdy  (cpu_rdy),
    .slv_cs   (slv_cs),
    .slv_addr (slv_addr),
    .slv_rd   (slv_rd),
    .slv_we   (slv_we),
    .slv_wdata(slv_wdata),
    .slv_rdata(slv_rdata),
    .slv_ack  (slv_ack),
    .bus_err  (bus_err),
    .err_clr  (err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst   = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_rd    = 1'b0;
    cpu_we    = 1'b0;
    slv_rdata = '0;
    slv_ack   = '0;
    err_clr   = 1'b0;
    tick();
    tick();
    chk("rst_rdy",   cpu_rdy,   1);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_cs",    slv_cs,    0);
    chk("rst_strb",  {slv_rd, slv_we}, 0);
    chk("rst_addr",  slv_addr,  0);
    chk("rst_wdata", slv_wdata, 0);
    chk("rst_err",   bus_err,   0);
    sys_rst = 1'b0;
    tick();

    // Region 0, wait 0: one ACCESS cycle, ready two cycles after request
    cpu_addr  = 16'h1234;
    cpu_rd    = 1'b1;
    slv_rdata = {8'h00, 8'h00, 8'h5A};
    tick();
    chk("r0_cs",   slv_cs,   3'b001);
    chk("r0_rd",   {slv_rd, slv_we}, 2'b10);
    chk("r0_addr", slv_addr, 16'h1234);
    chk("r0_stall", cpu_rdy, 0);
    tick();
    chk("r0_rdy",   cpu_rdy,   1);
    chk("r0_rdata", cpu_rdata, 8'h5A);
    chk("r0_done_cs", slv_cs,  0);
    cpu_rd = 1'b0;
    tick();
    chk("r0_idle_rdy", cpu_rdy, 1);

    // Region 1, wait 2: three ACCESS cycles, data only sampled on the last one
    cpu_addr  = 16'hA010;
    cpu_rd    = 1'b1;
    slv_rdata = {8'h00, 8'h77, 8'h00};
    tick();
    chk("r1_cs1",   slv_cs,   3'b010);
    chk("r1_addr",  slv_addr, 16'h0010);
    tick();
    chk("r1_cs2",   slv_cs,   3'b010);
    chk("r1_stall2", cpu_rdy, 0);
    tick();
    chk("r1_cs3",   slv_cs,   3'b010);
    chk("r1_stall3", cpu_rdy, 0);
    slv_rdata = {8'h00, 8'hC3, 8'h00};
    tick();
    chk("r1_rdy",   cpu_rdy,   1);
    chk("r1_rdata", cpu_rdata, 8'hC3);
    cpu_rd = 1'b0;
    tick();

    // Region 2 ack-mode write, ack sampled in third ACCESS cycle
    cpu_addr  = 16'hF001;
    cpu_wdata = 8'h41;
    cpu_we    = 1'b1;
    tick();
    chk("w2_cs",    slv_cs,    3'b100);
    chk("w2_strb",  {slv_rd, slv_we}, 2'b01);
    chk("w2_addr",  slv_addr,  16'h0001);
    chk("w2_wdata", slv_wdata, 8'h41);
    tick();
    chk("w2_stall2", cpu_rdy, 0);
    tick();
    chk("w2_stall3", cpu_rdy, 0);
    slv_ack = 3'b100;
    tick();
    slv_ack = 3'b000;
    chk("w2_rdy",   cpu_rdy,   1);
    chk("w2_cs_off", slv_cs,   0);
    chk("w2_err",   bus_err,   0);
    chk("w2_rdata_kept", cpu_rdata, 8'hC3);
    cpu_we = 1'b0;
    tick();

    // Region 2 read with no ack: timeout after 8 ACCESS cycles
    cpu_addr  = 16'hF000;
    cpu_rd    = 1'b1;
    slv_rdata = {8'h99, 8'h00, 8'h00};
    tick();
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("tmo_stall%0d", i), {cpu_rdy, slv_cs}, 4'b0100);
    end
    tick();
    chk("tmo_rdy",   cpu_rdy,   1);
    chk("tmo_rdata", cpu_rdata, 8'hFF);
    chk("tmo_err",   bus_err,   1);
    cpu_rd  = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_clr", bus_err, 0);

    // Unmapped read, with err_clr coinciding with the error-setting edge
    cpu_addr  = 16'hC000;
    cpu_rd    = 1'b1;
    tick();
    chk("um_cs",   slv_cs, 0);
    chk("um_strb", {slv_rd, slv_we}, 0);
    chk("um_stall", cpu_rdy, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    cpu_rd  = 1'b0;
    chk("um_rdy",   cpu_rdy,   1);
    chk("um_rdata", cpu_rdata, 8'hFF);
    chk("um_err_set_wins", bus_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("um_clr", bus_err, 0);

    // Read and write together behave as a write, no error
    cpu_addr  = 16'h0004;
    cpu_wdata = 8'h3C;
    cpu_rd    = 1'b1;
    cpu_we    = 1'b1;
    tick();
    chk("rw_strb", {slv_rd, slv_we}, 2'b01);
    chk("rw_cs",   slv_cs, 3'b001);
    tick();
    cpu_rd = 1'b0;
    cpu_we = 1'b0;
    chk("rw_err",   bus_err,   0);
    chk("rw_rdata", cpu_rdata, 8'hFF);
    tick();

    // Reset in the middle of a region 1 access
    cpu_addr = 16'hA000;
    cpu_rd   = 1'b1;
    tick();
    chk("rst_mid_cs_before", slv_cs, 3'b010);
    tick();
    sys_rst = 1'b1;
    tick();
    chk("rst_mid_cs",    slv_cs,    0);
    chk("rst_mid_rdy",   cpu_rdy,   1);
    chk("rst_mid_rdata", cpu_rdata, 0);
    chk("rst_mid_strb",  {slv_rd, slv_we}, 0);
    chk("rst_mid_err",   bus_err,   0);
    sys_rst = 1'b0;
    cpu_rd  = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
